// File: rtl/id_ex_operand_stage_if.sv
// ID/EX operand stage bus.
// Groups every non-clock/reset signal of the ID->EX pipeline register:
//   ID side      : decoded instruction fields and control bits
//   Forward side : EX/MEM and MEM/WB destination/result state
//   Control      : hold, flush in; hazard_stall out
//   EX side      : final ALU operands, store data and control bits
// slave  modport : the operand stage itself
// master modport : the surrounding pipeline (drives ID/forward/control)
interface id_ex_operand_stage_if;
  logic        id_valid;
  logic [31:0] id_rs_data, id_rt_data;
  logic [4:0]  id_rs_addr, id_rt_addr;
  logic        id_uses_rs, id_uses_rt;
  logic [4:0]  id_shamt;
  logic [31:0] id_imm32;
  logic        id_ALUSrc1, id_ALUSrc2;
  logic [5:0]  id_ALUFun;
  logic [4:0]  id_rd;
  logic        id_regwrite, id_memread, id_memwrite;

  logic        exmem_valid, exmem_regwrite;
  logic [4:0]  exmem_rd;
  logic [31:0] exmem_result;
  logic        memwb_valid, memwb_regwrite;
  logic [4:0]  memwb_rd;
  logic [31:0] memwb_data;

  logic        hold, flush;
  logic        hazard_stall;

  logic        ex_valid;
  logic [31:0] ex_A, ex_B;
  logic [5:0]  ex_ALUFun;
  logic [31:0] ex_store_data;
  logic [4:0]  ex_rd;
  logic        ex_regwrite, ex_memread, ex_memwrite;

  modport slave (
    input  id_valid, id_rs_data, id_rt_data, id_rs_addr, id_rt_addr,
           id_uses_rs, id_uses_rt, id_shamt, id_imm32, id_ALUSrc1, id_ALUSrc2,
           id_ALUFun, id_rd, id_regwrite, id_memread, id_memwrite,
           exmem_valid, exmem_regwrite, exmem_rd, exmem_result,
           memwb_valid, memwb_regwrite, memwb_rd, memwb_data,
           hold, flush,
    output hazard_stall, ex_valid, ex_A, ex_B, ex_ALUFun, ex_store_data,
           ex_rd, ex_regwrite, ex_memread, ex_memwrite
  );

  modport master (
    output id_valid, id_rs_data, id_rt_data, id_rs_addr, id_rt_addr,
           id_uses_rs, id_uses_rt, id_shamt, id_imm32, id_ALUSrc1, id_ALUSrc2,
           id_ALUFun, id_rd, id_regwrite, id_memread, id_memwrite,
           exmem_valid, exmem_regwrite, exmem_rd, exmem_result,
           memwb_valid, memwb_regwrite, memwb_rd, memwb_data,
           hold, flush,
    input  hazard_stall, ex_valid, ex_A, ex_B, ex_ALUFun, ex_store_data,
           ex_rd, ex_regwrite, ex_memread, ex_memwrite
  );
endinterface

// File: rtl/id_ex_operand_stage.sv
// ID/EX pipeline register with operand select, EX/MEM + MEM/WB forwarding
// and load-use hazard detection (one bubble per hazard).
// Ports:
//   clk   : rising-edge clock
//   reset : asynchronous active-high reset, clears every registered field
//   b     : id_ex_operand_stage_if.slave (ID fields, forward sources,
//           hold/flush in, hazard_stall and ex_* operands out)
// For shifts, ex_A carries the shift amount (shamt for sll/srl/sra, full
// forwarded rs for variable shifts -- the shifter uses only ex_A[4:0]).
module id_ex_operand_stage (
  input  logic                         clk,
  input  logic                         reset,
  id_ex_operand_stage_if.slave         b
);

  typedef struct packed {
    logic        valid;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic [4:0]  rs_addr;
    logic [4:0]  rt_addr;
    logic [4:0]  shamt;
    logic [31:0] imm;
    logic        alusrc1;
    logic        alusrc2;
    logic [5:0]  alufun;
    logic [4:0]  rd;
    logic        regwrite;
    logic        memread;
    logic        memwrite;
  } ex_reg_t;

  ex_reg_t st_q, st_d, id_fields;
  logic    hazard;
  logic [31:0] fwd_rs, fwd_rt;

  assign id_fields = '{
    valid:    b.id_valid,
    rs_data:  b.id_rs_data,
    rt_data:  b.id_rt_data,
    rs_addr:  b.id_rs_addr,
    rt_addr:  b.id_rt_addr,
    shamt:    b.id_shamt,
    imm:      b.id_imm32,
    alusrc1:  b.id_ALUSrc1,
    alusrc2:  b.id_ALUSrc2,
    alufun:   b.id_ALUFun,
    rd:       b.id_rd,
    regwrite: b.id_regwrite,
    memread:  b.id_memread,
    memwrite: b.id_memwrite
  };

  // Load in EX whose destination is read by the instruction in ID.
  // Driven regardless of hold; hold simply wins at the register.
  assign hazard = b.id_valid && st_q.valid && st_q.memread && (st_q.rd != 5'd0) &&
                  ((b.id_uses_rs && (b.id_rs_addr == st_q.rd)) ||
                   (b.id_uses_rt && (b.id_rt_addr == st_q.rd)));

  // Bubbles are all-zero: valid and control bits must clear, data zeroed too.
  always_comb begin
    st_d = id_fields;
    if (b.flush)      st_d = '0;
    else if (b.hold)  st_d = st_q;
    else if (hazard)  st_d = '0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) st_q <= '0;
    else       st_q <= st_d;
  end

  // EX/MEM is younger than MEM/WB so it takes priority; $0 never forwards.
  function automatic logic [31:0] fwd(input logic [4:0] addr, input logic [31:0] regval,
                                      input logic xv, input logic xw, input logic [4:0] xrd,
                                      input logic [31:0] xres,
                                      input logic wv, input logic ww, input logic [4:0] wrd,
                                      input logic [31:0] wres);
    if (xv && xw && (xrd != 5'd0) && (xrd == addr))      return xres;
    else if (wv && ww && (wrd != 5'd0) && (wrd == addr)) return wres;
    else                                                 return regval;
  endfunction

  assign fwd_rs = fwd(st_q.rs_addr, st_q.rs_data,
                      b.exmem_valid, b.exmem_regwrite, b.exmem_rd, b.exmem_result,
                      b.memwb_valid, b.memwb_regwrite, b.memwb_rd, b.memwb_data);
  assign fwd_rt = fwd(st_q.rt_addr, st_q.rt_data,
                      b.exmem_valid, b.exmem_regwrite, b.exmem_rd, b.exmem_result,
                      b.memwb_valid, b.memwb_regwrite, b.memwb_rd, b.memwb_data);

  assign b.hazard_stall  = hazard;
  assign b.ex_valid      = st_q.valid;
  assign b.ex_A          = st_q.alusrc1 ? {27'b0, st_q.shamt} : fwd_rs;
  assign b.ex_B          = st_q.alusrc2 ? st_q.imm : fwd_rt;
  assign b.ex_ALUFun     = st_q.alufun;
  assign b.ex_store_data = fwd_rt;
  assign b.ex_rd         = st_q.rd;
  assign b.ex_regwrite   = st_q.valid & st_q.regwrite;
  assign b.ex_memread    = st_q.valid & st_q.memread;
  assign b.ex_memwrite   = st_q.valid & st_q.memwrite;

endmodule

// File: tb/tb_id_ex_operand_stage.sv
module tb_id_ex_operand_stage;
  logic clk, reset;
  int   nvec, nerr;

  id_ex_operand_stage_if bus();

  id_ex_operand_stage dut (
    .clk   (clk),
    .reset (reset),
    .b     (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_id();
    bus.id_valid = 0; bus.id_rs_data = 0; bus.id_rt_data = 0;
    bus.id_rs_addr = 0; bus.id_rt_addr = 0; bus.id_uses_rs = 0; bus.id_uses_rt = 0;
    bus.id_shamt = 0; bus.id_imm32 = 0; bus.id_ALUSrc1 = 0; bus.id_ALUSrc2 = 0;
    bus.id_ALUFun = 0; bus.id_rd = 0;
    bus.id_regwrite = 0; bus.id_memread = 0; bus.id_memwrite = 0;
  endtask

  task automatic clr_fwd();
    bus.exmem_valid = 0; bus.exmem_regwrite = 0; bus.exmem_rd = 0; bus.exmem_result = 0;
    bus.memwb_valid = 0; bus.memwb_regwrite = 0; bus.memwb_rd = 0; bus.memwb_data = 0;
  endtask

  initial begin
    nvec = 0; nerr = 0;
    reset = 1'b1;
    clr_id(); clr_fwd();
    bus.hold = 0; bus.flush = 0;
    step(); step();

    // reset state
    chk("rst_valid", 32'(bus.ex_valid), 32'd0);
    chk("rst_A", bus.ex_A, 32'd0);
    chk("rst_B", bus.ex_B, 32'd0);
    chk("rst_fun", 32'(bus.ex_ALUFun), 32'd0);
    chk("rst_hz", 32'(bus.hazard_stall), 32'd0);
    reset = 1'b0;

    // sll $10, $9, 5
    bus.id_valid = 1; bus.id_shamt = 5; bus.id_ALUSrc1 = 1;
    bus.id_rt_addr = 9; bus.id_uses_rt = 1; bus.id_rt_data = 32'h1;
    bus.id_ALUFun = 6'b100000; bus.id_rd = 10; bus.id_regwrite = 1;
    step();
    chk("sll_A", bus.ex_A, 32'h5);
    chk("sll_B", bus.ex_B, 32'h1);
    chk("sll_fun", 32'(bus.ex_ALUFun), 32'h20);
    chk("sll_valid", 32'(bus.ex_valid), 32'd1);
    chk("sll_rw", 32'(bus.ex_regwrite), 32'd1);

    // hold 3 cycles with a different instruction waiting in ID
    bus.hold = 1; bus.id_shamt = 7; bus.id_rt_data = 32'hABCD; bus.id_rd = 3;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("hold_A", bus.ex_A, 32'h5);
      chk("hold_B", bus.ex_B, 32'h1);
      chk("hold_rd", 32'(bus.ex_rd), 32'd10);
    end
    // flush + hold -> bubble
    bus.flush = 1;
    step();
    chk("fh_valid", 32'(bus.ex_valid), 32'd0);
    chk("fh_rw", 32'(bus.ex_regwrite), 32'd0);
    bus.flush = 0; bus.hold = 0;

    // srav $11, $9, $8 : rs=$8 (shift amount), rt=$9
    clr_id();
    bus.id_valid = 1; bus.id_rs_addr = 8; bus.id_rs_data = 32'h11; bus.id_uses_rs = 1;
    bus.id_rt_addr = 9; bus.id_rt_data = 32'h22; bus.id_uses_rt = 1;
    bus.id_ALUFun = 6'b100011; bus.id_rd = 11; bus.id_regwrite = 1;
    step();
    bus.exmem_valid = 1; bus.exmem_regwrite = 1; bus.exmem_rd = 8; bus.exmem_result = 32'hFFFFFFE3;
    bus.memwb_valid = 1; bus.memwb_regwrite = 1; bus.memwb_rd = 8; bus.memwb_data = 32'h1234;
    #1 chk("fwd_exmem_A", bus.ex_A, 32'hFFFFFFE3);
    chk("fwd_B_none", bus.ex_B, 32'h22);
    bus.exmem_rd = 0;
    #1 chk("fwd_memwb_A", bus.ex_A, 32'h1234);
    bus.memwb_valid = 0;
    #1 chk("fwd_none_A", bus.ex_A, 32'h11);
    bus.exmem_rd = 9;
    #1 chk("fwd_rt_B", bus.ex_B, 32'hFFFFFFE3);
    chk("fwd_rt_st", bus.ex_store_data, 32'hFFFFFFE3);
    bus.exmem_regwrite = 0;
    #1 chk("fwd_norw_B", bus.ex_B, 32'h22);
    clr_fwd();

    // rs=$0 with both stages claiming $0 -> registered value
    bus.id_rs_addr = 0; bus.id_rs_data = 32'h55;
    step();
    bus.exmem_valid = 1; bus.exmem_regwrite = 1; bus.exmem_rd = 0; bus.exmem_result = 32'hDEAD;
    bus.memwb_valid = 1; bus.memwb_regwrite = 1; bus.memwb_rd = 0; bus.memwb_data = 32'hBEEF;
    #1 chk("r0_A", bus.ex_A, 32'h55);
    clr_fwd();

    // load-use: lw $9, 4($29) then sllv $11, $10, $9
    clr_id();
    bus.id_valid = 1; bus.id_rs_addr = 29; bus.id_uses_rs = 1; bus.id_ALUSrc2 = 1;
    bus.id_imm32 = 32'h4; bus.id_memread = 1; bus.id_regwrite = 1; bus.id_rd = 9;
    step();
    chk("lw_mr", 32'(bus.ex_memread), 32'd1);
    clr_id();
    bus.id_valid = 1; bus.id_rs_addr = 9; bus.id_uses_rs = 1; bus.id_rs_data = 32'h0;
    bus.id_rt_addr = 10; bus.id_uses_rt = 1; bus.id_rt_data = 32'hF0;
    bus.id_ALUFun = 6'b100000; bus.id_rd = 11; bus.id_regwrite = 1;
    #1 chk("lu_hz", 32'(bus.hazard_stall), 32'd1);
    step();
    chk("lu_bubble", 32'(bus.ex_valid), 32'd0);
    chk("lu_bub_rw", 32'(bus.ex_regwrite), 32'd0);
    chk("lu_hz_off", 32'(bus.hazard_stall), 32'd0);
    bus.exmem_valid = 1; bus.exmem_regwrite = 1; bus.exmem_rd = 9; bus.exmem_result = 32'h1000;
    step();
    clr_fwd();
    bus.memwb_valid = 1; bus.memwb_regwrite = 1; bus.memwb_rd = 9; bus.memwb_data = 32'hCAFE0003;
    #1 chk("lu_valid", 32'(bus.ex_valid), 32'd1);
    chk("lu_A", bus.ex_A, 32'hCAFE0003);
    chk("lu_B", bus.ex_B, 32'hF0);
    clr_fwd();

    // hold beats hazard_stall: no bubble while held
    clr_id();
    bus.id_valid = 1; bus.id_rs_addr = 29; bus.id_uses_rs = 1; bus.id_ALUSrc2 = 1;
    bus.id_imm32 = 32'h8; bus.id_memread = 1; bus.id_regwrite = 1; bus.id_rd = 12;
    step();
    clr_id();
    bus.id_valid = 1; bus.id_rt_addr = 12; bus.id_uses_rt = 1; bus.id_rd = 13;
    bus.hold = 1;
    #1 chk("hh_hz", 32'(bus.hazard_stall), 32'd1);
    step();
    chk("hh_valid", 32'(bus.ex_valid), 32'd1);
    chk("hh_mr", 32'(bus.ex_memread), 32'd1);
    chk("hh_B", bus.ex_B, 32'h8);
    bus.hold = 0;

    // reset mid-operation: sra $4, $5, 3
    clr_id();
    bus.id_valid = 1; bus.id_ALUSrc1 = 1; bus.id_shamt = 3; bus.id_rt_addr = 5;
    bus.id_uses_rt = 1; bus.id_rt_data = 32'h80000000; bus.id_ALUFun = 6'b100011;
    bus.id_rd = 4; bus.id_regwrite = 1;
    step();
    chk("sra_valid", 32'(bus.ex_valid), 32'd1);
    chk("sra_A", bus.ex_A, 32'h3);
    clr_id();
    #2 reset = 1'b1;
    #1 chk("mrst_valid", 32'(bus.ex_valid), 32'd0);
    chk("mrst_A", bus.ex_A, 32'd0);
    chk("mrst_B", bus.ex_B, 32'd0);
    chk("mrst_fun", 32'(bus.ex_ALUFun), 32'd0);
    chk("mrst_rd", 32'(bus.ex_rd), 32'd0);
    chk("mrst_rw", 32'(bus.ex_regwrite), 32'd0);
    chk("mrst_hz", 32'(bus.hazard_stall), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
